dotprod_pe: RTL and testbench
=============================

# dotprod_pe

Parametrised dot-product processing element, the successor to the fixed 8-lane int8 PE. Each accepted beat multiplies LANES element pairs, reduces them in an adder tree, and accumulates into a vector result. A vector ends on a beat flagged `in_last`. Adds signed/unsigned mode, optional saturation with overflow flag, and valid/ready flow control. Sits between operand buffers and the result writeback in the vector ALU.

## Interface
- `LANES`, 8: multiplier lanes per beat; power of two, 2–32.
- `IN_W`, 8: operand width.
- `ACC_W`, 32: accumulator/result width; must be ≥ 2*IN_W+clog2(LANES) (elaboration error otherwise).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_a` in LANES*IN_W: operands A, lane 0 in LSBs.
- `in_b` in LANES*IN_W: operands B, same packing.
- `in_last` in 1: final beat of the vector.
- `signed_mode` in 1: 1 = two's-complement operands, 0 = unsigned; sampled per beat.
- `sat_en` in 1: 1 = saturate the accumulator to signed ACC_W range, 0 = wrap; sampled per beat.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_data` out ACC_W: signed vector result.
- `out_ovf` out 1: the vector overflowed signed ACC_W at least once.

## Operation
- Pipeline stages:
  - S1 registers the LANES products. Each product is 2*IN_W bits, sign- or zero-extended per `signed_mode`.
  - S2 registers the tree sum, extended to ACC_W.
  - S3 holds the accumulator `acc`, a sticky `ovf_acc`, and the output register.
- `in_last`, `sat_en` and a valid bit travel down the pipeline with each beat.
- S3 on a valid beat:
  - Compute `nxt = acc + sum` at ACC_W+1 bits.
  - Overflow means `nxt` lies outside the signed ACC_W range.
  - With `sat_en` set, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1). Otherwise truncate.
  - Update `ovf_acc |= overflow`.
- Last beat at S3: `out_data` ← result, `out_ovf` ← `ovf_acc|overflow`, `out_valid` ← 1. `acc` and `ovf_acc` clear to 0.
- Non-last beat at S3: `acc` ← result. Outputs unchanged.
- Stall: `stall = out_valid && !out_ready`.
  - `in_ready = !stall`, combinational.
  - On stall, every pipeline register holds, including valids and `acc`.
- Pop and refill: if `out_ready` is high and a last beat reaches S3 on the same edge, `out_valid` stays 1 and the new result loads. Results are never dropped or reordered.
- A single-beat vector is a beat with `in_last`=1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ovf`=0, all stage valids=0, `acc`=0, `ovf_acc`=0. `in_ready`=1 while `out_valid`=0.
- Latency: a last beat accepted at edge E0 gives `out_valid`=1 after edge E0+2, i.e. 3 edges with no stall.
- Throughput: one beat per cycle without backpressure. Each stall cycle adds exactly one cycle.
- Reset mid-vector: asserting `rst` discards all in-flight beats and the partial accumulator. The next vector starts from 0.
- `in_a`, `in_b`, `signed_mode`, `sat_en` and `in_last` are don't-care when `in_valid`=0 or `in_ready`=0.

## Structure
- Package `dotprod_pkg` holds:
  - a `clog2` function;
  - the tree width constant, 2*IN_W+clog2(LANES);
  - a `sat_add` function taking (a, b, sat) and returning (sum, ovf).
- Sub-module `dotprod_tree`: a combinational binary adder tree over LANES signed inputs. The S2 register is in the parent.
- Lane multipliers are generate-loop instances in the parent.

## Test plan
- Unsigned max (defaults): one beat, all a=255, b=255, `in_last`=1 → `out_data`=520200 (0x0007F008), `out_ovf`=0, valid 3 edges after acceptance.
- Signed extreme: one beat, all a=-128, b=127, `signed_mode`=1 → `out_data`=-130048.
- Multi-beat: 3 back-to-back beats, lane i a=i+1, b=1, last on beat 3 → single result 108. The next vector with a=b=1 (one beat) → 8, with no leakage from the prior vector.
- Saturation, ACC_W=20, unsigned a=b=255:
  - `sat_en`=1, two beats → 524287, `out_ovf`=1.
  - `sat_en`=0, same stimulus → -8176, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 while streaming four single-beat vectors (sums 8, 16, 24, 32) → `in_ready` drops and the pipeline freezes. Release `out_ready` → results appear in order 8, 16, 24, 32, none lost or duplicated.
- Reset mid-vector: after 2 non-last beats (sum 8 each), pulse `rst` → all outputs 0, `in_ready`=1. A following single last beat with sum 8 → `out_data`=8.

Source files
------------

// File: rtl/dotprod_pkg.sv
// Shared helpers for the dot-product PE: width arithmetic and the
// saturating accumulator add used by the S3 stage.
package dotprod_pkg;

    // Widest accumulator the saturating add supports (one bit of headroom).
    localparam int unsigned MAX_ACC_W = 63;

    typedef logic signed [MAX_ACC_W:0] wide_t;

    typedef struct packed {
        wide_t sum;
        logic  ovf;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Width that holds a full LANES-wide sum of IN_W x IN_W products.
    function automatic int unsigned tree_w(input int unsigned in_w, input int unsigned lanes);
        return 2 * in_w + clog2(lanes);
    endfunction

    localparam int unsigned TREE_W = tree_w(8, 8);

    // a + b checked against the signed w-bit range; clamps when sat is set,
    // otherwise returns the exact sum for the caller to truncate.
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                         input logic sat, input int unsigned w);
        sat_res_t r;
        wide_t    nxt;
        wide_t    max_v;
        wide_t    min_v;
        nxt   = a + b;
        max_v = wide_t'((64'd1 << (w - 1)) - 64'd1);
        min_v = ~max_v;
        r.ovf = (nxt > max_v) || (nxt < min_v);
        if (r.ovf && sat) begin
            r.sum = (nxt < 0) ? min_v : max_v;
        end else begin
            r.sum = nxt;
        end
        return r;
    endfunction

endpackage

// File: rtl/dotprod_tree.sv
// Combinational balanced binary adder tree over LANES signed terms.
// Each level halves the node count; the result register lives in the parent.
module dotprod_tree
    import dotprod_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned IN_SUM_W = 17,
    parameter int unsigned OUT_W    = 20
) (
    input  logic [LANES*IN_SUM_W-1:0] terms,
    output logic signed [OUT_W-1:0]   sum
);

    localparam int unsigned LEVELS = clog2(LANES);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic signed [OUT_W-1:0] n [LANES >> l];
        for (genvar j = 0; j < (LANES >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
                logic signed [IN_SUM_W-1:0] leaf;
                assign leaf = terms[j*IN_SUM_W +: IN_SUM_W];
                assign n[j] = OUT_W'(leaf);
            end else begin : g_add
                assign n[j] = g_lvl[l-1].n[2*j] + g_lvl[l-1].n[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LEVELS].n[0];

endmodule

// File: rtl/dotprod_pe.sv
// Dot-product processing element: LANES products per beat (S1), adder-tree
// reduction (S2), then accumulation with optional saturation and a sticky
// overflow flag (S3). A single stall condition freezes the whole pipeline.
module dotprod_pe
    import dotprod_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*IN_W-1:0]   in_a,
    input  logic [LANES*IN_W-1:0]   in_b,
    input  logic                    in_last,
    input  logic                    signed_mode,
    input  logic                    sat_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf
);

    // Products carry one extra bit so unsigned and signed values share a
    // single signed tree without ambiguity.
    localparam int unsigned PROD_W = 2 * IN_W + 1;
    localparam int unsigned SUM_W  = tree_w(IN_W, LANES) + 1;

    if (ACC_W < tree_w(IN_W, LANES)) begin : g_bad_acc_w
        $error("dotprod_pe: ACC_W too narrow for LANES and IN_W");
    end
    if (ACC_W > MAX_ACC_W) begin : g_bad_acc_max
        $error("dotprod_pe: ACC_W exceeds supported maximum");
    end
    if (LANES < 2 || LANES > 32 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("dotprod_pe: LANES must be a power of two in 2..32");
    end

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic [LANES*PROD_W-1:0] prod_next;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [IN_W:0]     a_x;
        logic signed [IN_W:0]     b_x;
        logic signed [PROD_W-1:0] p;
        assign a_x = {signed_mode & in_a[i*IN_W + IN_W - 1], in_a[i*IN_W +: IN_W]};
        assign b_x = {signed_mode & in_b[i*IN_W + IN_W - 1], in_b[i*IN_W +: IN_W]};
        assign p   = PROD_W'(a_x) * PROD_W'(b_x);
        assign prod_next[i*PROD_W +: PROD_W] = p;
    end

    logic                    v1, last1, sat1;
    logic [LANES*PROD_W-1:0] prods1;
    logic                    v2, last2, sat2;
    logic signed [ACC_W-1:0] sum2;
    logic signed [SUM_W-1:0] tree_sum;

    dotprod_tree #(
        .LANES    (LANES),
        .IN_SUM_W (PROD_W),
        .OUT_W    (SUM_W)
    ) u_tree (
        .terms (prods1),
        .sum   (tree_sum)
    );

    // S1/S2: register products and the reduced sum, holding on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            last1  <= 1'b0;
            sat1   <= 1'b0;
            prods1 <= '0;
            v2     <= 1'b0;
            last2  <= 1'b0;
            sat2   <= 1'b0;
            sum2   <= '0;
        end else if (!stall) begin
            v1     <= in_valid;
            last1  <= in_last;
            sat1   <= sat_en;
            prods1 <= prod_next;
            v2     <= v1;
            last2  <= last1;
            sat2   <= sat1;
            sum2   <= ACC_W'(tree_sum);
        end
    end

    logic signed [ACC_W-1:0] acc;
    logic                    ovf_acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    ovf_nxt;
    sat_res_t                sres;

    // S3 combinational: accumulate the incoming beat sum with range check.
    always_comb begin
        sres    = sat_add(wide_t'(acc), wide_t'(sum2), sat2, ACC_W);
        acc_nxt = ACC_W'(sres.sum);
        ovf_nxt = sres.ovf;
    end

    // S3 registers: accumulator, sticky overflow and the output slot; a last
    // beat may refill the slot on the same edge it is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            if (v2 && last2) begin
                out_valid <= 1'b1;
                out_data  <= acc_nxt;
                out_ovf   <= ovf_acc | ovf_nxt;
                acc       <= '0;
                ovf_acc   <= 1'b0;
            end else begin
                if (v2) begin
                    acc     <= acc_nxt;
                    ovf_acc <= ovf_acc | ovf_nxt;
                end
                if (out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dotprod_pe.sv
// Scoreboard bench for dotprod_pe: a 32-bit and a 20-bit accumulator instance
// share stimulus; a reference model pushes expected results per vector.
module tb_dotprod_pe;

    localparam int LANES = 8;
    localparam int IN_W  = 8;
    localparam int VW    = LANES * IN_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          signed_mode = 1'b0;
    logic          sat_en = 1'b0;
    logic          out_ready = 1'b1;
    logic [VW-1:0] in_a = '0;
    logic [VW-1:0] in_b = '0;

    logic          rdy32, rdy20, ov32, ov20, of32, of20;
    logic [31:0]   d32;
    logic [19:0]   d20;

    always #5 clk = ~clk;

    dotprod_pe #(.LANES(LANES), .IN_W(IN_W), .ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .signed_mode(signed_mode),
        .sat_en(sat_en), .out_valid(ov32), .out_ready(out_ready),
        .out_data(d32), .out_ovf(of32)
    );

    dotprod_pe #(.LANES(LANES), .IN_W(IN_W), .ACC_W(20)) dut20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy20),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .signed_mode(signed_mode),
        .sat_en(sat_en), .out_valid(ov20), .out_ready(out_ready),
        .out_data(d20), .out_ovf(of20)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint data;
        logic   ovf;
    } exp_t;

    exp_t   q32[$];
    exp_t   q20[$];
    exp_t   e32, e20;
    longint acc_m[2];
    logic   ovf_m[2];

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] ramp();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'(i + 1);
        return r;
    endfunction

    function automatic longint lane_val(input logic [IN_W-1:0] x, input logic sgn);
        longint v;
        v = longint'(x);
        if (sgn && x[IN_W-1]) v = v - (longint'(1) << IN_W);
        return v;
    endfunction

    function automatic longint beat_sum(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                        input logic sgn);
        longint s;
        s = 0;
        for (int i = 0; i < LANES; i++)
            s = s + lane_val(a[i*IN_W +: IN_W], sgn) * lane_val(b[i*IN_W +: IN_W], sgn);
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            ovf_m[k] = 1'b0;
        end
    endtask

    task automatic model_beat(input longint s, input logic sat, input logic last);
        int     w;
        longint mx, mn, nxt, res;
        logic   ov;
        exp_t   e;
        for (int k = 0; k < 2; k++) begin
            w   = (k == 0) ? 32 : 20;
            mx  = (longint'(1) << (w - 1)) - 1;
            mn  = -mx - 1;
            nxt = acc_m[k] + s;
            ov  = (nxt > mx) || (nxt < mn);
            if (ov && sat) res = (nxt > 0) ? mx : mn;
            else begin
                res = nxt <<< (64 - w);
                res = res >>> (64 - w);
            end
            if (last) begin
                e.data = res;
                e.ovf  = ovf_m[k] | ov;
                if (k == 0) q32.push_back(e);
                else        q20.push_back(e);
                acc_m[k] = 0;
                ovf_m[k] = 1'b0;
            end else begin
                acc_m[k] = res;
                ovf_m[k] = ovf_m[k] | ov;
            end
        end
    endtask

    // Drives one beat from a falling edge, waits (bounded) for acceptance,
    // then records it in the model.
    task automatic send_beat(input logic [VW-1:0] a, input logic [VW-1:0] b,
                             input logic sgn, input logic sat, input logic last);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; signed_mode = sgn; sat_en = sat; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!(rdy32 && rdy20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL accept_timeout waited=%0d cycles required=<100", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(beat_sum(a, b, sgn), sat, last);
    endtask

    task automatic wait_drain(output logic ok);
        int n;
        n = 0;
        while ((q32.size() != 0 || q20.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        ok = (q32.size() == 0) && (q20.size() == 0);
    endtask

    // Scoreboard: every output handshake pops and compares the oldest entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov32 && out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    failures++;
                    $display("FAIL result32_unexpected got=%0d required=none", $signed(d32));
                end else begin
                    e32 = q32.pop_front();
                    if (longint'($signed(d32)) !== e32.data || of32 !== e32.ovf) begin
                        failures++;
                        $display("FAIL result32 got=%0d ovf=%0b required=%0d ovf=%0b",
                                 $signed(d32), of32, e32.data, e32.ovf);
                    end
                end
            end
            if (ov20 && out_ready) begin
                checks++;
                if (q20.size() == 0) begin
                    failures++;
                    $display("FAIL result20_unexpected got=%0d required=none", $signed(d20));
                end else begin
                    e20 = q20.pop_front();
                    if (longint'($signed(d20)) !== e20.data || of20 !== e20.ovf) begin
                        failures++;
                        $display("FAIL result20 got=%0d ovf=%0b required=%0d ovf=%0b",
                                 $signed(d20), of20, e20.data, e20.ovf);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ov32 !== 1'b0 || d32 !== 32'd0 || of32 !== 1'b0 || rdy32 !== 1'b1) begin
            failures++;
            $display("FAIL reset32 got v=%0b d=%0d o=%0b r=%0b required 0 0 0 1",
                     ov32, d32, of32, rdy32);
        end
        checks++;
        if (ov20 !== 1'b0 || d20 !== 20'd0 || of20 !== 1'b0 || rdy20 !== 1'b1) begin
            failures++;
            $display("FAIL reset20 got v=%0b d=%0d o=%0b r=%0b required 0 0 0 1",
                     ov20, d20, of20, rdy20);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_unsigned_max();
        logic ok;
        send_beat(fill(255), fill(255), 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (ov32 !== (e == 3)) begin
                failures++;
                $display("FAIL latency edge=%0d got out_valid=%0b required=%0b", e, ov32, (e == 3));
            end
        end
        checks++;
        if (d32 !== 32'h0007F008 || of32 !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_max got=%0d ovf=%0b required=520200 ovf=0", d32, of32);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drain_unsigned got=pending required=empty"); end
    endtask

    task automatic test_signed_extreme();
        logic ok;
        send_beat(fill(-128), fill(127), 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if ($signed(d32) !== -32'sd130048) begin
            failures++;
            $display("FAIL signed_extreme got=%0d required=-130048", $signed(d32));
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drain_signed got=pending required=empty"); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        send_beat(ramp(), fill(1), 1'b0, 1'b0, 1'b0);
        send_beat(ramp(), fill(1), 1'b0, 1'b0, 1'b0);
        send_beat(ramp(), fill(1), 1'b0, 1'b0, 1'b1);
        send_beat(fill(1), fill(1), 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (d32 !== 32'd108) begin
            failures++;
            $display("FAIL multi_beat got=%0d required=108", d32);
        end
        @(negedge clk);
        checks++;
        if (d32 !== 32'd8) begin
            failures++;
            $display("FAIL next_vector got=%0d required=8", d32);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drain_b2b got=pending required=empty"); end
    endtask

    task automatic test_saturation();
        logic ok;
        send_beat(fill(255), fill(255), 1'b0, 1'b1, 1'b0);
        send_beat(fill(255), fill(255), 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if ($signed(d20) !== 20'sd524287 || of20 !== 1'b1) begin
            failures++;
            $display("FAIL sat_clamp got=%0d ovf=%0b required=524287 ovf=1", $signed(d20), of20);
        end
        send_beat(fill(255), fill(255), 1'b0, 1'b0, 1'b0);
        send_beat(fill(255), fill(255), 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if ($signed(d20) !== -20'sd8176 || of20 !== 1'b1) begin
            failures++;
            $display("FAIL sat_wrap got=%0d ovf=%0b required=-8176 ovf=1", $signed(d20), of20);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drain_sat got=pending required=empty"); end
    endtask

    task automatic test_backpressure();
        logic ok;
        @(posedge clk);
        #1 out_ready = 1'b0;
        send_beat(fill(1), fill(1), 1'b0, 1'b0, 1'b1);
        send_beat(fill(2), fill(1), 1'b0, 1'b0, 1'b1);
        send_beat(fill(3), fill(1), 1'b0, 1'b0, 1'b1);
        fork
            send_beat(fill(4), fill(1), 1'b0, 1'b0, 1'b1);
            begin
                repeat (6) @(negedge clk);
                checks++;
                if (rdy32 !== 1'b0 || ov32 !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_ready got in_ready=%0b out_valid=%0b required 0 1", rdy32, ov32);
                end
                checks++;
                if (d32 !== 32'd8) begin
                    failures++;
                    $display("FAIL stall_hold got=%0d required=8", d32);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drain_backpressure got=pending required=empty"); end
    endtask

    task automatic test_reset_mid_vector();
        logic ok;
        send_beat(fill(1), fill(1), 1'b0, 1'b0, 1'b0);
        send_beat(fill(1), fill(1), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ov32 !== 1'b0 || d32 !== 32'd0 || of32 !== 1'b0 || rdy32 !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got v=%0b d=%0d o=%0b r=%0b required 0 0 0 1",
                     ov32, d32, of32, rdy32);
        end
        rst = 1'b0;
        model_reset();
        send_beat(fill(1), fill(1), 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (d32 !== 32'd8) begin
            failures++;
            $display("FAIL after_reset got=%0d required=8", d32);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drain_reset got=pending required=empty"); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_unsigned_max();
        test_signed_extreme();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_reset_mid_vector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
